// File: rtl/smc_core.sv
// smc_core: register/dispatch core of the System Management Controller.
// Bridges an I2C slave byte interface to a keyboard and a mouse ps2_port.
//   clk6x, reset              : 48 MHz clock, synchronous active-high reset
//   devsel, rw_bit            : I2C transaction for this slave, direction
//   rxbyte, rxbyte_v          : byte written by the master
//   txbyte, txbyte_deq        : registered byte to send, consumed strobe
//   {kbd,mse}_rx, _rx_v       : received PS2 codes
//   {kbd,mse}_tx, _tx_v       : command byte/request to the ps2_port
//   {kbd,mse}_busy/acked/errd : ps2_port command handshake
module smc_core #(
  parameter int unsigned KBD_DEPTH_LOG2 = 3,
  parameter int unsigned MSE_DEPTH_LOG2 = 4,
  parameter int unsigned MSE_PKT_BYTES  = 3
) (
  input  logic       clk6x,
  input  logic       reset,
  input  logic       devsel,
  input  logic       rw_bit,
  input  logic [7:0] rxbyte,
  input  logic       rxbyte_v,
  output logic [7:0] txbyte,
  input  logic       txbyte_deq,
  input  logic [7:0] kbd_rx,
  input  logic       kbd_rx_v,
  input  logic [7:0] mse_rx,
  input  logic       mse_rx_v,
  output logic [7:0] kbd_tx,
  output logic       kbd_tx_v,
  output logic [7:0] mse_tx,
  output logic       mse_tx_v,
  input  logic       kbd_busy,
  input  logic       mse_busy,
  input  logic       kbd_acked,
  input  logic       mse_acked,
  input  logic       kbd_errd,
  input  logic       mse_errd
);

  localparam logic [7:0] REG_KBD_DATA = 8'h07;
  localparam logic [7:0] REG_KBD_STAT = 8'h18;
  localparam logic [7:0] REG_KBD_CMD  = 8'h19;
  localparam logic [7:0] REG_MSE_DATA = 8'h21;
  localparam logic [7:0] REG_MSE_CMD  = 8'h22;
  localparam logic [7:0] REG_MSE_STAT = 8'h23;
  localparam logic [7:0] REG_FLAGS    = 8'h24;

  localparam int unsigned KBD_DEPTH = 1 << KBD_DEPTH_LOG2;
  localparam int unsigned MSE_DEPTH = 1 << MSE_DEPTH_LOG2;
  localparam logic [3:0] PKT_IDX = 4'(MSE_PKT_BYTES);
  localparam logic [MSE_DEPTH_LOG2:0] PKT_CNT = (MSE_DEPTH_LOG2+1)'(MSE_PKT_BYTES);

  typedef enum logic [7:0] {
    ST_IDLE = 8'h00,
    ST_PEND = 8'h01,
    ST_ACK  = 8'hFA,
    ST_ERR  = 8'hFE
  } status_t;

  logic [7:0]                kbd_mem [KBD_DEPTH];
  logic [KBD_DEPTH_LOG2-1:0] kbd_rd, kbd_wr;
  logic [KBD_DEPTH_LOG2:0]   kbd_cnt;
  logic [7:0]                mse_mem [MSE_DEPTH];
  logic [MSE_DEPTH_LOG2-1:0] mse_rd, mse_wr;
  logic [MSE_DEPTH_LOG2:0]   mse_cnt;

  status_t    kbd_status, mse_status;
  logic       kbd_ovf, mse_ovf;
  logic [3:0] idx;
  logic [7:0] regnum;
  logic       rd_q, pkt_ok, kbd_sent;

  logic       rd_txn, wr_byte, first_rd, pkt_ok_eff, mse_pkt_avail, kbd_nempty;
  logic       kbd_deq, mse_deq, kbd_enq, mse_enq;
  logic       kbd_acc, mse_acc, kbd_clr, mse_clr, flag_clr;
  logic [7:0] tx_next;

  function automatic status_t next_status(status_t cur, logic acc, logic ack,
                                          logic err, logic clr);
    if (acc)      return ST_PEND;
    else if (ack) return ST_ACK;
    else if (err) return ST_ERR;
    else if (clr) return ST_IDLE;
    return cur;
  endfunction

  assign rd_txn        = devsel & rw_bit;
  assign wr_byte       = devsel & ~rw_bit & rxbyte_v;
  assign first_rd      = rd_txn & ~rd_q;
  assign mse_pkt_avail = (mse_cnt >= PKT_CNT);
  assign kbd_nempty    = (kbd_cnt != '0);
  // Packet availability is frozen at the start of a read so a packet is
  // either streamed whole or not touched at all.
  assign pkt_ok_eff    = first_rd ? mse_pkt_avail : pkt_ok;

  // kbd_sent tracks whether the registered txbyte came from the FIFO, so a
  // byte landing in an empty FIFO during a dequeue is never dropped unseen.
  assign kbd_deq = rd_txn & txbyte_deq & (regnum == REG_KBD_DATA) & kbd_sent & kbd_nempty;
  assign mse_deq = rd_txn & txbyte_deq & (regnum == REG_MSE_DATA) & pkt_ok_eff &
                   (idx < PKT_IDX) & (mse_cnt != '0);
  assign kbd_enq = kbd_rx_v & (~kbd_cnt[KBD_DEPTH_LOG2] | kbd_deq);
  assign mse_enq = mse_rx_v & (~mse_cnt[MSE_DEPTH_LOG2] | mse_deq);

  assign kbd_acc = wr_byte & (idx == 4'd1) & (regnum == REG_KBD_CMD) &
                   ~kbd_tx_v & (kbd_status != ST_PEND);
  assign mse_acc = wr_byte & (idx == 4'd1) & (regnum == REG_MSE_CMD) &
                   ~mse_tx_v & (mse_status != ST_PEND);
  assign kbd_clr = rd_txn & txbyte_deq & (regnum == REG_KBD_STAT) &
                   ((kbd_status == ST_ACK) | (kbd_status == ST_ERR)) & (txbyte == kbd_status);
  assign mse_clr = rd_txn & txbyte_deq & (regnum == REG_MSE_STAT) &
                   ((mse_status == ST_ACK) | (mse_status == ST_ERR)) & (txbyte == mse_status);
  assign flag_clr = rd_txn & txbyte_deq & (regnum == REG_FLAGS);

  always_comb begin
    tx_next = 8'hFF;
    case (regnum)
      REG_KBD_DATA: tx_next = kbd_nempty ? kbd_mem[kbd_rd] : 8'h00;
      REG_KBD_STAT: tx_next = kbd_status;
      REG_MSE_DATA: tx_next = (rd_txn & pkt_ok_eff & (idx < PKT_IDX)) ? mse_mem[mse_rd] : 8'h00;
      REG_MSE_STAT: tx_next = mse_status;
      REG_FLAGS:    tx_next = {mse_ovf, kbd_ovf, 4'b0000, mse_pkt_avail, kbd_nempty};
      default:      tx_next = 8'hFF;
    endcase
  end

  always_ff @(posedge clk6x) begin
    if (kbd_enq) kbd_mem[kbd_wr] <= kbd_rx;
    if (mse_enq) mse_mem[mse_wr] <= mse_rx;
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      txbyte     <= 8'hFF;
      kbd_tx     <= '0;
      kbd_tx_v   <= 1'b0;
      mse_tx     <= '0;
      mse_tx_v   <= 1'b0;
      kbd_rd     <= '0;
      kbd_wr     <= '0;
      kbd_cnt    <= '0;
      mse_rd     <= '0;
      mse_wr     <= '0;
      mse_cnt    <= '0;
      kbd_status <= ST_IDLE;
      mse_status <= ST_IDLE;
      kbd_ovf    <= 1'b0;
      mse_ovf    <= 1'b0;
      idx        <= '0;
      regnum     <= '0;
      rd_q       <= 1'b0;
      pkt_ok     <= 1'b0;
      kbd_sent   <= 1'b0;
    end else begin
      txbyte   <= tx_next;
      kbd_sent <= kbd_nempty;
      rd_q     <= rd_txn;
      if (first_rd) pkt_ok <= mse_pkt_avail;

      if (!devsel)                                     idx <= '0;
      else if ((rxbyte_v | txbyte_deq) && idx != 4'hF) idx <= idx + 4'd1;

      if (wr_byte && idx == 4'd0) regnum <= rxbyte;

      if (kbd_acc) begin
        kbd_tx   <= rxbyte;
        kbd_tx_v <= 1'b1;
      end else if (kbd_tx_v && !kbd_busy) begin
        kbd_tx_v <= 1'b0;
      end
      if (mse_acc) begin
        mse_tx   <= rxbyte;
        mse_tx_v <= 1'b1;
      end else if (mse_tx_v && !mse_busy) begin
        mse_tx_v <= 1'b0;
      end

      kbd_status <= next_status(kbd_status, kbd_acc, kbd_acked, kbd_errd, kbd_clr);
      mse_status <= next_status(mse_status, mse_acc, mse_acked, mse_errd, mse_clr);

      if (kbd_enq) kbd_wr <= kbd_wr + 1'b1;
      if (kbd_deq) kbd_rd <= kbd_rd + 1'b1;
      case ({kbd_enq, kbd_deq})
        2'b10:   kbd_cnt <= kbd_cnt + 1'b1;
        2'b01:   kbd_cnt <= kbd_cnt - 1'b1;
        default: ;
      endcase
      if (mse_enq) mse_wr <= mse_wr + 1'b1;
      if (mse_deq) mse_rd <= mse_rd + 1'b1;
      case ({mse_enq, mse_deq})
        2'b10:   mse_cnt <= mse_cnt + 1'b1;
        2'b01:   mse_cnt <= mse_cnt - 1'b1;
        default: ;
      endcase

      // A byte dropped in the same cycle as a flags read stays flagged.
      if (kbd_rx_v && !kbd_enq) kbd_ovf <= 1'b1;
      else if (flag_clr)        kbd_ovf <= 1'b0;
      if (mse_rx_v && !mse_enq) mse_ovf <= 1'b1;
      else if (flag_clr)        mse_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smc_core.sv
module tb_smc_core;

  localparam int KDEPTH = 8;
  localparam int MDEPTH = 16;
  localparam int PKT    = 3;

  logic       clk6x = 1'b0;
  logic       reset = 1'b1;
  logic       devsel = 1'b0, rw_bit = 1'b0;
  logic [7:0] rxbyte = '0;
  logic       rxbyte_v = 1'b0;
  logic [7:0] txbyte;
  logic       txbyte_deq = 1'b0;
  logic [7:0] kbd_rx = '0, mse_rx = '0;
  logic       kbd_rx_v = 1'b0, mse_rx_v = 1'b0;
  logic [7:0] kbd_tx, mse_tx;
  logic       kbd_tx_v, mse_tx_v;
  logic       kbd_busy = 1'b0, mse_busy = 1'b0;
  logic       kbd_acked = 1'b0, mse_acked = 1'b0;
  logic       kbd_errd = 1'b0, mse_errd = 1'b0;

  smc_core #(.KBD_DEPTH_LOG2(3), .MSE_DEPTH_LOG2(4), .MSE_PKT_BYTES(3)) dut (
    .clk6x(clk6x), .reset(reset), .devsel(devsel), .rw_bit(rw_bit),
    .rxbyte(rxbyte), .rxbyte_v(rxbyte_v), .txbyte(txbyte), .txbyte_deq(txbyte_deq),
    .kbd_rx(kbd_rx), .kbd_rx_v(kbd_rx_v), .mse_rx(mse_rx), .mse_rx_v(mse_rx_v),
    .kbd_tx(kbd_tx), .kbd_tx_v(kbd_tx_v), .mse_tx(mse_tx), .mse_tx_v(mse_tx_v),
    .kbd_busy(kbd_busy), .mse_busy(mse_busy), .kbd_acked(kbd_acked),
    .mse_acked(mse_acked), .kbd_errd(kbd_errd), .mse_errd(mse_errd)
  );

  initial forever #5 clk6x = ~clk6x;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Behavioural model: queues for the FIFOs, plain bytes for everything else.
  logic [7:0] kq[$], mq[$];
  logic       k_ovf, m_ovf;
  logic [7:0] k_st, m_st, m_regnum, k_cmd, m_cmd;
  logic       k_txv, m_txv;

  task automatic model_reset();
    kq.delete(); mq.delete();
    k_ovf = 0; m_ovf = 0; k_st = 8'h00; m_st = 8'h00;
    m_regnum = 8'h00; k_cmd = 8'h00; m_cmd = 8'h00; k_txv = 0; m_txv = 0;
  endtask

  function automatic logic [7:0] model_flags();
    return {m_ovf, k_ovf, 4'b0000, logic'(mq.size() >= PKT), logic'(kq.size() != 0)};
  endfunction

  task automatic model_push(input bit mouse, input logic [7:0] b);
    if (mouse) begin
      if (mq.size() == MDEPTH) m_ovf = 1; else mq.push_back(b);
    end else begin
      if (kq.size() == KDEPTH) k_ovf = 1; else kq.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk6x); #1;
  endtask

  task automatic ps2_rx(input bit mouse, input logic [7:0] b);
    if (mouse) begin mse_rx = b; mse_rx_v = 1; end
    else       begin kbd_rx = b; kbd_rx_v = 1; end
    tick();
    kbd_rx_v = 0; mse_rx_v = 0;
    model_push(mouse, b);
  endtask

  task automatic ps2_resp(input bit mouse, input bit ack, input bit err);
    if (mouse) begin mse_acked = ack; mse_errd = err; end
    else       begin kbd_acked = ack; kbd_errd = err; end
    tick();
    kbd_acked = 0; kbd_errd = 0; mse_acked = 0; mse_errd = 0;
    if (mouse) begin
      if (ack) m_st = 8'hFA; else if (err) m_st = 8'hFE;
    end else begin
      if (ack) k_st = 8'hFA; else if (err) k_st = 8'hFE;
    end
  endtask

  task automatic i2c_write(input logic [7:0] r, input int unsigned n, input logic [7:0] d);
    devsel = 1; rw_bit = 0;
    tick();
    for (int unsigned i = 0; i < n; i++) begin
      rxbyte = (i == 0) ? r : (i == 1) ? d : 8'($urandom);
      rxbyte_v = 1;
      tick();
      rxbyte_v = 0;
      tick(); tick();
    end
    devsel = 0;
    tick(); tick();
    m_regnum = r;
    if (n >= 2) begin
      if (r == 8'h19 && !k_txv && k_st != 8'h01) begin
        k_cmd = d; k_st = 8'h01; k_txv = kbd_busy;
      end
      if (r == 8'h22 && !m_txv && m_st != 8'h01) begin
        m_cmd = d; m_st = 8'h01; m_txv = mse_busy;
      end
    end
    check_eq("kbd_tx", kbd_tx, k_cmd);
    check_eq("kbd_tx_v", {7'b0, kbd_tx_v}, {7'b0, k_txv});
    check_eq("mse_tx", mse_tx, m_cmd);
    check_eq("mse_tx_v", {7'b0, mse_tx_v}, {7'b0, m_txv});
  endtask

  // Read n bytes from the current register; with race set, PS2 bytes may
  // arrive in the very cycle of each dequeue.
  task automatic i2c_read(input int unsigned n, input bit race);
    logic [7:0] exp, rb;
    bit pkt_ok, rk, rm;
    devsel = 1; rw_bit = 1;
    pkt_ok = (mq.size() >= PKT);
    repeat (4) tick();
    for (int unsigned k = 0; k < n; k++) begin
      case (m_regnum)
        8'h07:   exp = (kq.size() != 0) ? kq[0] : 8'h00;
        8'h18:   exp = k_st;
        8'h21:   exp = (pkt_ok && k < PKT && mq.size() != 0) ? mq[0] : 8'h00;
        8'h23:   exp = m_st;
        8'h24:   exp = model_flags();
        default: exp = 8'hFF;
      endcase
      check_eq($sformatf("rd%02h[%0d]", m_regnum, k), txbyte, exp);
      rb = 8'($urandom);
      rk = race && ($urandom_range(0, 1) == 1);
      rm = race && ($urandom_range(0, 1) == 1);
      txbyte_deq = 1;
      kbd_rx = rb; kbd_rx_v = rk;
      mse_rx = ~rb; mse_rx_v = rm;
      tick();
      txbyte_deq = 0; kbd_rx_v = 0; mse_rx_v = 0;
      case (m_regnum)
        8'h07: if (kq.size() != 0) void'(kq.pop_front());
        8'h18: if (k_st == 8'hFA || k_st == 8'hFE) k_st = 8'h00;
        8'h21: if (pkt_ok && k < PKT && mq.size() != 0) void'(mq.pop_front());
        8'h23: if (m_st == 8'hFA || m_st == 8'hFE) m_st = 8'h00;
        8'h24: begin k_ovf = 0; m_ovf = 0; end
        default: ;
      endcase
      if (rk) model_push(0, rb);
      if (rm) model_push(1, ~rb);
      repeat (4) tick();
    end
    devsel = 0; rw_bit = 0;
    tick(); tick();
  endtask

  task automatic read_reg(input logic [7:0] r, input int unsigned n);
    i2c_write(r, 1, 8'h00);
    i2c_read(n, 0);
  endtask

  initial begin
    logic [7:0] rsel;
    model_reset();
    repeat (3) tick();
    check_eq("rst_txbyte", txbyte, 8'hFF);
    check_eq("rst_kbd_tx", kbd_tx, 8'h00);
    check_eq("rst_mse_tx", mse_tx, 8'h00);
    check_eq("rst_tx_v", {6'b0, kbd_tx_v, mse_tx_v}, 8'h00);
    reset = 0;
    tick();
    check_eq("idle_txbyte", txbyte, 8'hFF);

    // Keyboard stream
    ps2_rx(0, 8'h1C); ps2_rx(0, 8'hF0); ps2_rx(0, 8'h1C);
    read_reg(8'h07, 4);
    read_reg(8'h24, 1);

    // Keyboard command held by busy
    kbd_busy = 1;
    i2c_write(8'h19, 2, 8'hFF);
    repeat (50) tick();
    check_eq("kbd_tx_held", kbd_tx, 8'hFF);
    check_eq("kbd_tx_v_held", {7'b0, kbd_tx_v}, 8'h01);
    read_reg(8'h18, 1);
    kbd_busy = 0;
    tick(); tick();
    k_txv = 0;
    check_eq("kbd_tx_v_drop", {7'b0, kbd_tx_v}, 8'h00);
    ps2_resp(0, 1, 0);
    read_reg(8'h18, 1);
    read_reg(8'h18, 1);

    // Mouse packet atomicity
    ps2_rx(1, 8'h08); ps2_rx(1, 8'h01);
    read_reg(8'h21, 3);
    ps2_rx(1, 8'hFF);
    read_reg(8'h21, 3);
    read_reg(8'h24, 1);

    // Keyboard overflow
    for (int i = 0; i < 9; i++) ps2_rx(0, 8'(8'h30 + i));
    read_reg(8'h24, 1);
    read_reg(8'h24, 1);
    read_reg(8'h07, 9);

    // Mouse command collision
    i2c_write(8'h22, 2, 8'hF4);
    i2c_write(8'h22, 2, 8'hEA);
    check_eq("mse_tx_kept", mse_tx, 8'hF4);
    ps2_resp(1, 0, 1);
    read_reg(8'h23, 2);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: ps2_rx($urandom_range(0, 1) == 1, 8'($urandom));
        3: begin
          case ($urandom_range(0, 2))
            0:       rsel = 8'h19;
            1:       rsel = 8'h22;
            default: rsel = 8'($urandom);
          endcase
          i2c_write(rsel, $urandom_range(1, 3), 8'($urandom));
        end
        4: ps2_resp($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
        default: begin
          case ($urandom_range(0, 6))
            0:       rsel = 8'h07;
            1:       rsel = 8'h18;
            2:       rsel = 8'h21;
            3:       rsel = 8'h23;
            4:       rsel = 8'h24;
            5:       rsel = 8'h19;
            default: rsel = 8'($urandom);
          endcase
          i2c_write(rsel, 1, 8'h00);
          i2c_read($urandom_range(1, 5), $urandom_range(0, 1) == 1);
        end
      endcase
    end

    // Reset in the middle of a mouse packet read
    for (int i = 0; i < 20; i++) ps2_rx(1, 8'(8'hA0 + i));
    kbd_busy = 1;
    ps2_resp(0, 1, 0);
    i2c_write(8'h19, 2, 8'hED);
    i2c_write(8'h21, 1, 8'h00);
    devsel = 1; rw_bit = 1;
    repeat (4) tick();
    check_eq("mid_rd_byte0", txbyte, mq[0]);
    txbyte_deq = 1; tick(); txbyte_deq = 0;
    repeat (2) tick();
    reset = 1;
    tick(); tick();
    devsel = 0; rw_bit = 0; kbd_busy = 0;
    check_eq("mid_rst_txbyte", txbyte, 8'hFF);
    reset = 0;
    model_reset();
    tick(); tick();
    check_eq("post_rst_txbyte", txbyte, 8'hFF);
    check_eq("post_rst_kbd_tx", kbd_tx, 8'h00);
    check_eq("post_rst_tx_v", {6'b0, kbd_tx_v, mse_tx_v}, 8'h00);
    read_reg(8'h24, 1);
    read_reg(8'h18, 1);
    read_reg(8'h23, 1);
    read_reg(8'h21, 3);
    read_reg(8'h07, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/smc_core.md
Name: smc_core

Overview:
- Register/dispatch core of the System Management Controller, generalised to two PS2 channels: keyboard and mouse.
- Sits between an i2c_slave device interface (slave 0x42) and two ps2_port instances.
- Holds a per-channel receive FIFO and command/status tracking.
- Serves single-byte keyboard reads and atomic multi-byte mouse-packet reads over I2C.

Parameters:
- KBD_DEPTH_LOG2, 3, keyboard FIFO holds 2**KBD_DEPTH_LOG2 bytes.
- MSE_DEPTH_LOG2, 4, mouse FIFO holds 2**MSE_DEPTH_LOG2 bytes.
- MSE_PKT_BYTES, 3, bytes per mouse packet (3 or 4).

Ports:
- clk6x  in  1  48 MHz system clock.
- reset  in  1  synchronous reset, active-high.
- devsel  in  1  I2C transaction for this slave ongoing.
- rw_bit  in  1  1 = I2C read; valid while devsel=1.
- rxbyte  in  8  byte written by the master.
- rxbyte_v  in  1  rxbyte valid, 1T.
- txbyte  out  8  next byte to send; valid whenever devsel & rw_bit.
- txbyte_deq  in  1  txbyte consumed, 1T.
- kbd_rx, mse_rx  in  8  received PS2 code, per channel.
- kbd_rx_v, mse_rx_v  in  1  code valid, 1T.
- kbd_tx, mse_tx  out  8  command byte to the ps2_port.
- kbd_tx_v, mse_tx_v  out  1  command request; held until the port's busy=0.
- kbd_busy, mse_busy  in  1  ps2_port busy.
- kbd_acked, mse_acked  in  1  command ACKed, 1T.
- kbd_errd, mse_errd  in  1  command NACK/error, 1T.

Behaviour:
- Registers:
  - 0x07 read keyboard FIFO.
  - 0x18 read keyboard status.
  - 0x19 write keyboard command.
  - 0x21 read mouse packet.
  - 0x22 write mouse command.
  - 0x23 read mouse status.
  - 0x24 read FIFO flags.
  - Any other register reads 0xFF; writes to it are ignored.
- Reset: txbyte=0xFF, kbd_tx=mse_tx=0x00, kbd_tx_v=mse_tx_v=0, both FIFOs empty, both statuses 0x00, overflow flags 0, byte index 0, regnum 0x00. Reset mid-transaction aborts everything; nothing is dequeued.
- Byte index (4 bits, saturating at 15):
  - Cleared whenever devsel=0.
  - Incremented on each rxbyte_v and on each txbyte_deq.
- Write path:
  - Index 0: rxbyte becomes regnum.
  - Index 1 to 0x19/0x22: latch the command, assert tx_v, set status=0x01 (PENDING).
  - Bytes at index ≥2 are ignored.
  - If tx_v is already 1 or status is PENDING, the new command is dropped and status is unchanged.
- tx_v: cleared on the first cycle with busy=0 after it was set. The port samples the command on that cycle.
- Status per channel:
  - 0x00 IDLE, 0x01 PENDING, 0xFA ACK, 0xFE ERR.
  - acked has priority over errd in the same cycle.
  - A txbyte_deq of a status register whose value is 0xFA or 0xFE returns it to 0x00; the sampled value is still what is sent.
- FIFOs:
  - Circular, with a count of width DEPTH_LOG2+1.
  - A rx_v while full drops the byte and sets the sticky overflow flag.
  - Enqueue and dequeue in the same cycle are both allowed, including when full (the enqueue succeeds after the dequeue).
- Register 0x24: bit0 kbd non-empty, bit1 mouse holds ≥ MSE_PKT_BYTES, bit6 kbd overflow, bit7 mouse overflow. A txbyte_deq of 0x24 clears both overflow flags.
- Keyboard read (0x07):
  - txbyte = FIFO head, or 0x00 if empty, updated every cycle.
  - On txbyte_deq with a nonempty FIFO, dequeue one byte.
  - Consecutive reads stream successive bytes.
- Mouse read (0x21):
  - On the first cycle of devsel & rw_bit, latch pkt_ok = (count ≥ MSE_PKT_BYTES).
  - If pkt_ok: each txbyte_deq dequeues one byte while index < MSE_PKT_BYTES. Afterwards txbyte=0x00 and nothing is dequeued.
  - If not pkt_ok: txbyte=0x00 for the whole transaction and nothing is dequeued.
  - This guarantees no partial packet is consumed.
- txbyte latency: a registered output, updated 1T after its source changes. The i2c_slave's bit-level timing gives ample slack.
- Source changes racing a dequeue: a rx_v arriving in the same cycle as a txbyte_deq never corrupts the byte being sent. The head pointer advances only on deq.

Test Plan:
- Keyboard stream: enqueue 0x1C,0xF0,0x1C; I2C write 0x07 then read 4 bytes -> 0x1C,0xF0,0x1C,0x00; FIFO empty; 0x24 reads 0x00.
- Keyboard command: write 0x19,0xFF with busy=1 for 50T -> kbd_tx=0xFF, kbd_tx_v held until busy falls; 0x18 reads 0x01, then 0xFA after acked; a second 0x18 read -> 0x00.
- Mouse atomicity: enqueue 0x08,0x01 only, read 0x21 for 3 bytes -> 0x00,0x00,0x00 with count still 2; enqueue 0xFF, read again -> 0x08,0x01,0xFF and count 0.
- Overflow: enqueue 9 keyboard bytes (DEPTH 8) -> the 9th is dropped; 0x24 reads 0x41; a re-read of 0x24 gives 0x01.
- Command collision: write 0x22,0xF4 then 0x22,0xEA while PENDING -> mse_tx stays 0xF4; errd pulse -> 0x23 reads 0xFE.
- Reset mid-read: assert reset during a 0x21 read after 1 byte -> txbyte=0xFF, FIFOs empty, statuses 0x00, tx_v=0.
